multiword_add_sequencer: RTL and testbench
==========================================

Name: multiword_add_sequencer

Overview:
- Sequences the existing 8-bit ripple_carry_adder slice (ports a, b, cy_in, sum, cy_out) to add or subtract operands WORDS*8 bits wide.
- Processes one byte per clock, least significant byte first, chaining carry through a register between cycles.
- Sits between the KGPRisc ALU control and the byte-wide adder datapath.
- Trades latency for area versus a full-width adder.

Parameters:
- WORDS, 4, number of 8-bit slices; operand width W = 8*WORDS; legal range 2..16.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- op_sub  in  1  0 = a+b+cy_in; 1 = a-b (a + ~b + 1, cy_in ignored); latched at start.
- a  in  W  operand A; latched at start.
- b  in  W  operand B; latched at start.
- cy_in  in  1  carry-in for add; latched at start.
- busy  out  1  high while slices are being computed (RUN).
- done  out  1  one-cycle pulse: result valid.
- sum  out  W  result register.
- cy_out  out  1  final carry; for subtract, 1 = no borrow.
- overflow  out  1  signed two's-complement overflow of the W-bit operation.
- zero  out  1  sum == 0.

Behaviour:
- Clocking and reset are fixed: one clock; reset is asynchronous and active-low.
- While rst_n=0, immediately and asynchronously:
  - busy=0, done=0, sum=0, cy_out=0, overflow=0, zero=0;
  - state=IDLE, slice index=0, carry register=0.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE:
  - start=1 at edge k latches a, b_eff (= op_sub ? ~b : b) and carry = (op_sub ? 1 : cy_in).
  - Same edge: clears sum to 0, sets index=0, moves to RUN.
  - start=0 keeps IDLE.
- RUN:
  - Adder slice inputs are byte[index] of the latched a and b_eff, plus the carry register.
  - Each edge writes slice sum into sum[8*index+7 : 8*index], loads carry with slice cy_out, and increments index.
  - On the edge that writes index=WORDS-1:
    - cy_out <= slice cy_out;
    - overflow <= (a_msb == b_eff_msb) && (slice_sum_msb != a_msb);
    - zero <= (all previously written bytes == 0) && (slice sum == 0);
    - state <= DONE.
- DONE:
  - done=1 for exactly this one cycle; busy=0.
  - If start=1, the request is accepted exactly as in IDLE and goes to RUN (back-to-back operation); otherwise goes to IDLE.
- Latency: start sampled at edge k gives busy=1 in cycles k..k+WORDS-1 and done=1 in the cycle following edge k+WORDS. For WORDS=4, done is high 4 cycles after the start edge.
- Throughput: one operation per WORDS+1 cycles.
- start while busy (RUN) is ignored: not queued, latched operands unaffected.
- Input operand changes after the start edge have no effect.
- sum, cy_out, overflow and zero hold their values after DONE until the next accepted start.
  - sum is cleared on acceptance and partially updated during RUN.
  - Flags update only on the final-slice edge.
- Reset mid-RUN aborts the operation and returns all outputs to reset values. No done pulse is issued for the aborted operation.
- done and busy are never high in the same cycle.

Test Plan:
- WORDS=4: a=0x000000FF, b=0x00000001, op_sub=0, cy_in=0 -> sum=0x00000100, cy_out=0, overflow=0, zero=0; done exactly 4 cycles after start edge; busy high 4 cycles.
- a=0xFFFFFFFF, b=0x00000001, cy_in=0, add -> sum=0x00000000, cy_out=1, zero=1, overflow=0; repeat with cy_in=1, b=0 -> same result.
- a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, overflow=1, cy_out=0; then a=0x80000000, b=0x80000000 -> sum=0, overflow=1, cy_out=1, zero=1.
- Subtract:
  - a=5, b=7, op_sub=1, cy_in=1 (ignored) -> sum=0xFFFFFFFE, cy_out=0, overflow=0.
  - a=7, b=7 -> sum=0, cy_out=1, zero=1.
- Pulse start again mid-RUN with different operands -> ignored, first result unchanged. Hold start=1 through DONE -> second operation accepted, its done pulse 5 cycles after the first.
- Assert rst_n=0 for 1 cycle during RUN (index=2) -> outputs zero asynchronously, state IDLE, no done. Next start yields correct result from scratch.

Source files
------------

// File: rtl/multiword_add_sequencer.sv
// Multi-word add/subtract sequencer: drives one 8-bit adder slice per clock,
// least significant byte first, chaining the carry through a register.
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               op_sub,
    input  logic [8*WORDS-1:0] a,
    input  logic [8*WORDS-1:0] b,
    input  logic               cy_in,
    output logic               busy,
    output logic               done,
    output logic [8*WORDS-1:0] sum,
    output logic               cy_out,
    output logic               overflow,
    output logic               zero
);

    localparam int W  = 8 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q;
    logic [W-1:0]    sum_q, sum_d;
    logic [IW-1:0]   idx_q;
    logic            cy_q;
    logic            cyo_q, ovf_q, zero_q;
    logic            accept, last;
    logic [7:0]      slice_a, slice_b, slice_sum;
    logic            slice_cy;

    assign accept = start && ((state_q == IDLE) || (state_q == DONE));
    assign last   = (state_q == RUN) && (idx_q == IW'(WORDS - 1));

    // Byte-wide adder slice fed from the latched operands and carry register
    assign slice_a = a_q[{idx_q, 3'b000} +: 8];
    assign slice_b = b_q[{idx_q, 3'b000} +: 8];
    assign {slice_cy, slice_sum} = {1'b0, slice_a} + {1'b0, slice_b} + {8'd0, cy_q};

    always_comb begin
        sum_d = sum_q;
        sum_d[{idx_q, 3'b000} +: 8] = slice_sum;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (last) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            sum_q  <= '0;
            idx_q  <= '0;
            cy_q   <= 1'b0;
            cyo_q  <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= op_sub ? ~b : b;
            cy_q  <= op_sub ? 1'b1 : cy_in;
            sum_q <= '0;
            idx_q <= '0;
        end else if (state_q == RUN) begin
            sum_q <= sum_d;
            cy_q  <= slice_cy;
            idx_q <= idx_q + 1'b1;
            if (last) begin
                // upper bytes of sum_q are still cleared, so this covers all lower bytes
                cyo_q  <= slice_cy;
                ovf_q  <= (a_q[W-1] == b_q[W-1]) && (slice_sum[7] != a_q[W-1]);
                zero_q <= (sum_q == '0) && (slice_sum == 8'h00);
            end
        end
    end

    assign sum      = sum_q;
    assign cy_out   = cyo_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Randomized self-checking bench for multiword_add_sequencer against an
// arithmetic reference model.
module tb_multiword_add_sequencer;

    localparam int WORDS = 4;
    localparam int W     = 8 * WORDS;

    logic         clk, rst_n, start, op_sub, cy_in;
    logic [W-1:0] a, b, sum;
    logic         busy, done, cy_out, overflow, zero;

    int total = 0;
    int bad   = 0;

    multiword_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_sub(op_sub),
        .a(a), .b(b), .cy_in(cy_in), .busy(busy), .done(done),
        .sum(sum), .cy_out(cy_out), .overflow(overflow), .zero(zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the full-width operands
    task automatic model(input bit sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                         input bit c, output logic [W-1:0] es, output bit ecy,
                         output bit eovf, output bit ez);
        longint ua, ub, sa, sb, ur, sr, lim;
        ua  = longint'(av);
        ub  = longint'(bv);
        sa  = longint'(signed'(av));
        sb  = longint'(signed'(bv));
        lim = longint'(1) << (W - 1);
        if (sub) begin
            ur  = ua - ub;
            sr  = sa - sb;
            ecy = (ua >= ub);
        end else begin
            ur  = ua + ub + longint'(c);
            sr  = sa + sb + longint'(c);
            ecy = (ur >= (longint'(1) << W));
        end
        es   = ur[W-1:0];
        eovf = (sr >= lim) || (sr < -lim);
        ez   = (es == '0);
    endtask

    task automatic run_op(input bit sub, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit c, input bit poke);
        logic [W-1:0] es;
        bit ecy, eovf, ez;
        int n, nb;
        bit both;
        model(sub, av, bv, c, es, ecy, eovf, ez);
        @(negedge clk);
        op_sub = sub; a = av; b = bv; cy_in = c; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom; b = $urandom; op_sub = 1'($urandom); cy_in = 1'($urandom);
        n = 0; nb = 0; both = 0;
        while (!done && n < 20) begin
            if (busy) nb++;
            if (busy && done) both = 1;
            if (poke && n == 1) start = 1'b1;
            if (poke && n == 2) start = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        start = 1'b0;
        chk("latency", 64'(n), 64'd4);
        chk("busy_cycles", 64'(nb), 64'd4);
        chk("busy_done_overlap", 64'(both || (busy && done)), 64'd0);
        chk("sum", 64'(sum), 64'(es));
        chk("cy_out", 64'(cy_out), 64'(ecy));
        chk("overflow", 64'(overflow), 64'(eovf));
        chk("zero", 64'(zero), 64'(ez));
        @(posedge clk);
        #1;
        chk("done_pulse", 64'(done), 64'd0);
        chk("sum_hold", 64'(sum), 64'(es));
    endtask

    initial begin
        logic [W-1:0] es1, es2;
        bit c1, o1, z1, c2, o2, z2;
        int n;
        bit saw;

        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; cy_in = 1'b0; a = '0; b = '0;
        #1;
        chk("reset_outs", 64'({busy, done, sum, cy_out, overflow, zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(0, 32'h000000FF, 32'h00000001, 0, 0);
        run_op(0, 32'hFFFFFFFF, 32'h00000001, 0, 0);
        run_op(0, 32'hFFFFFFFF, 32'h00000000, 1, 0);
        run_op(0, 32'h7FFFFFFF, 32'h00000001, 0, 0);
        run_op(0, 32'h80000000, 32'h80000000, 0, 0);
        run_op(1, 32'h00000005, 32'h00000007, 1, 0);
        run_op(1, 32'h00000007, 32'h00000007, 0, 0);
        run_op(1, 32'h00000000, 32'h80000000, 0, 0);
        run_op(0, 32'h12345678, 32'h11111111, 0, 1);

        // back-to-back: start held through RUN and DONE
        model(0, 32'h01020304, 32'h10203040, 1, es1, c1, o1, z1);
        model(1, 32'h00000010, 32'h00000020, 0, es2, c2, o2, z2);
        @(negedge clk);
        op_sub = 0; a = 32'h01020304; b = 32'h10203040; cy_in = 1; start = 1'b1;
        @(posedge clk);
        #1;
        op_sub = 1; a = 32'h00000010; b = 32'h00000020; cy_in = 0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_lat1", 64'(n), 64'd4);
        chk("b2b_sum1", 64'(sum), 64'(es1));
        chk("b2b_flags1", 64'({cy_out, overflow, zero}), 64'({c1, o1, z1}));
        n = 0;
        do begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end while (!done && n < 20);
        chk("b2b_lat2", 64'(n), 64'd5);
        chk("b2b_sum2", 64'(sum), 64'(es2));
        chk("b2b_flags2", 64'({cy_out, overflow, zero}), 64'({c2, o2, z2}));

        // reset mid-RUN at index 2
        @(negedge clk);
        op_sub = 0; a = 32'h01010101; b = 32'h01010101; cy_in = 0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("partial_sum", 64'(sum), 64'h0000_0202);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outs", 64'({busy, done, sum, cy_out, overflow, zero}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        saw = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) saw = 1;
        end
        chk("abort_no_done", 64'(saw), 64'd0);
        run_op(0, 32'h01010101, 32'h01010101, 0, 0);

        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if (i % 7 == 0) rb = ra;
            if (i % 11 == 0) rb = ~ra;
            run_op(1'($urandom), ra, rb, 1'($urandom), (i % 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
